// File: rtl/demux_byte_serializer.sv
// demux_byte_serializer: accepts one byte per valid/ready handshake and
// serializes it onto a/sel for the 1-to-8 demux, with per-bit strobes and an
// end-of-frame pulse for the downstream capture stage.
module demux_byte_serializer #(
  parameter int unsigned GAP       = 0,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       a,
  output logic [2:0] sel,
  output logic       a_valid,
  output logic       done
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;
  localparam int unsigned GW = 4;

  localparam logic [GW-1:0] GAP_LD   = GW'(GAP);
  localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  logic [DW-1:0]   data_q;
  logic [CW-1:0]   cnt;
  logic [GW-1:0]   gap_cnt;
  logic [CW-1:0]   cnt_nxt_c;
  logic [CW-1:0]   idx_first_c;
  logic [CW-1:0]   idx_nxt_c;

  // Bit index for a given position in the frame; sel always carries the index.
  function automatic logic [CW-1:0] bit_idx(input logic [CW-1:0] c);
    return MSB_FIRST ? (LAST_CNT - c) : c;
  endfunction

  // Next bit position and the indices for the first and next emitted bit.
  always_comb begin
    cnt_nxt_c   = cnt + CW'(1);
    idx_first_c = bit_idx(CW'(0));
    idx_nxt_c   = bit_idx(cnt_nxt_c);
  end

  // Frame FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data_q   <= '0;
      cnt      <= '0;
      gap_cnt  <= '0;
      a        <= 1'b0;
      sel      <= '0;
      a_valid  <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          a        <= 1'b0;
          sel      <= '0;
          a_valid  <= 1'b0;
          done     <= 1'b0;
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            data_q   <= in_data;
            cnt      <= '0;
            a        <= in_data[idx_first_c];
            sel      <= idx_first_c;
            a_valid  <= 1'b1;
            in_ready <= 1'b0;
            state    <= SEND;
          end
        end
        SEND: begin
          a_valid <= 1'b0;
          if (cnt == LAST_CNT) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (GAP_LD != '0) begin
            gap_cnt <= GAP_LD;
            state   <= WAIT;
          end else begin
            cnt     <= cnt_nxt_c;
            a       <= data_q[idx_nxt_c];
            sel     <= idx_nxt_c;
            a_valid <= 1'b1;
          end
        end
        WAIT: begin
          // a/sel hold through the gap; the final gap cycle launches the next bit.
          if (gap_cnt <= GW'(1)) begin
            cnt     <= cnt_nxt_c;
            a       <= data_q[idx_nxt_c];
            sel     <= idx_nxt_c;
            a_valid <= 1'b1;
            state   <= SEND;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        DONE: begin
          done     <= 1'b0;
          a        <= 1'b0;
          sel      <= '0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
